// File: rtl/sysarb_pkg.sv
// Shared types and constants for the round-robin Z80 bus arbiter / slave mux.
package sysarb_pkg;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  dmaster;
    logic        rd;
    logic        wr;
    logic        mreq;
    logic        iorq;
    logic        m1;
  } Z80MasterBus;

  typedef struct packed {
    logic [7:0] dslave;
    logic       mwait;
  } Z80SlaveBus;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWNED,
    ST_ACCESS,
    ST_ABORT
  } sysarb_state_e;

  localparam int unsigned WS_W          = 4;
  localparam logic [7:0]  UNMAPPED_DATA = 8'hFF;

  // Index width for n entries, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sysarb_mux_rr_arbiter.sv
// Combinational round-robin pick: first requester after the last owner, wrapping.
module rr_arbiter
  import sysarb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]        req,
  input  logic [idx_w(N)-1:0] last,
  output logic [idx_w(N)-1:0] winner,
  output logic                valid
);

  localparam int unsigned IW = idx_w(N);

  logic [IW-1:0] w_idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    w_idx  = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      w_idx = IW'((32'(last) + i) % N);
      if (!valid && req[w_idx]) begin
        valid  = 1'b1;
        winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/sysarb_mux.sv
// Multi-master Z80 bus arbiter with address-decoded slave select, inserted
// wait states and a stuck-wait timeout.
module sysarb_mux
  import sysarb_pkg::*;
#(
  parameter int unsigned                    MASTER_QTY = 2,
  parameter int unsigned                    SLAVE_QTY  = 4,
  parameter logic [SLAVE_QTY-1:0][15:0]     SLAVE_BASE = '0,
  parameter logic [SLAVE_QTY-1:0][15:0]     SLAVE_MASK = '0,
  parameter logic [SLAVE_QTY-1:0][WS_W-1:0] SLAVE_WS   = '0,
  parameter int unsigned                    TIMEOUT    = 255
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  Z80MasterBus [MASTER_QTY-1:0]      master_ins,
  input  logic        [MASTER_QTY-1:0]      req,
  input  logic        [MASTER_QTY-1:0]      strobe,
  input  Z80SlaveBus  [SLAVE_QTY-1:0]       slave_ins,
  output logic        [MASTER_QTY-1:0]      gnt,
  output Z80MasterBus                       master_out,
  output logic        [SLAVE_QTY-1:0]       slave_cs,
  output Z80SlaveBus                        slave_out,
  output logic                              decode_miss,
  output logic                              timeout_err
);

  localparam int unsigned   MW     = idx_w(MASTER_QTY);
  localparam int unsigned   SW     = idx_w(SLAVE_QTY);
  localparam int unsigned   TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_SAT = (TIMEOUT > 0) ? TW'(TIMEOUT) : {TW{1'b1}};

  sysarb_state_e        r_state, w_state_nxt;
  logic [MW-1:0]        r_owner, w_owner_nxt, w_arb_win;
  logic [MASTER_QTY-1:0] r_gnt, w_gnt_nxt;
  logic [SW-1:0]        r_sel, w_sel_nxt, w_dec_sel;
  logic                 r_hit, w_hit_nxt, w_dec_hit, w_arb_vld;
  logic [WS_W-1:0]      r_ws, w_ws_nxt;
  logic [TW-1:0]        r_to, w_to_nxt, w_to_inc;
  logic                 r_miss, w_miss_nxt, r_terr, w_terr_nxt;
  Z80MasterBus          w_own_bus;
  logic                 w_own_req, w_own_stb, w_mwait;

  assign w_own_bus = master_ins[r_owner];
  assign w_own_req = req[r_owner];
  assign w_own_stb = strobe[r_owner];
  assign w_mwait   = slave_out.mwait;
  assign w_to_inc  = (r_to == TO_SAT) ? r_to : r_to + 1'b1;

  rr_arbiter #(.N(MASTER_QTY)) u_arb (
    .req    (req),
    .last   (r_owner),
    .winner (w_arb_win),
    .valid  (w_arb_vld)
  );

  // Lowest-index region wins when several decode the same address.
  always_comb begin
    w_dec_sel = '0;
    w_dec_hit = 1'b0;
    for (int unsigned s = 0; s < SLAVE_QTY; s++) begin
      if (!w_dec_hit && ((w_own_bus.addr & SLAVE_MASK[s]) == SLAVE_BASE[s])) begin
        w_dec_hit = 1'b1;
        w_dec_sel = SW'(s);
      end
    end
  end

  always_comb begin
    master_out = '0;
    slave_cs   = '0;
    slave_out  = '{dslave: 8'h00, mwait: 1'b1};
    case (r_state)
      ST_OWNED: master_out = w_own_bus;
      ST_ACCESS: begin
        master_out = w_own_bus;
        if (r_hit) begin
          slave_cs[r_sel] = 1'b1;
          slave_out       = slave_ins[r_sel];
          if (r_ws != '0) slave_out.mwait = 1'b0;
        end else begin
          slave_out = '{dslave: UNMAPPED_DATA, mwait: 1'b1};
        end
      end
      ST_ABORT: begin
        master_out = w_own_bus;
        slave_out  = '{dslave: UNMAPPED_DATA, mwait: 1'b1};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_hit_nxt   = r_hit;
    w_ws_nxt    = r_ws;
    w_to_nxt    = r_to;
    w_miss_nxt  = 1'b0;
    w_terr_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_vld) begin
          w_state_nxt          = ST_OWNED;
          w_owner_nxt          = w_arb_win;
          w_gnt_nxt            = '0;
          w_gnt_nxt[w_arb_win] = 1'b1;
        end
      end
      ST_OWNED: begin
        if (w_own_stb) begin
          w_state_nxt = ST_ACCESS;
          w_sel_nxt   = w_dec_sel;
          w_hit_nxt   = w_dec_hit;
          w_ws_nxt    = w_dec_hit ? SLAVE_WS[w_dec_sel] : '0;
          w_to_nxt    = '0;
          w_miss_nxt  = !w_dec_hit;
        end else if (!w_own_req) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
        end
      end
      ST_ACCESS: begin
        if (r_ws != '0) w_ws_nxt = r_ws - 1'b1;
        if (!w_mwait) w_to_nxt = w_to_inc;
        // A falling strobe takes precedence over a timeout in the same cycle.
        if (!w_own_stb) begin
          w_state_nxt = ST_OWNED;
        end else if ((TIMEOUT != 0) && !w_mwait && (w_to_inc == TO_SAT)) begin
          w_state_nxt = ST_ABORT;
          w_terr_nxt  = 1'b1;
        end
      end
      ST_ABORT: begin
        if (!w_own_stb) w_state_nxt = ST_OWNED;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_owner <= MW'(MASTER_QTY - 1);
      r_gnt   <= '0;
      r_sel   <= '0;
      r_hit   <= 1'b0;
      r_ws    <= '0;
      r_to    <= '0;
      r_miss  <= 1'b0;
      r_terr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_hit   <= w_hit_nxt;
      r_ws    <= w_ws_nxt;
      r_to    <= w_to_nxt;
      r_miss  <= w_miss_nxt;
      r_terr  <= w_terr_nxt;
    end
  end

  assign gnt         = r_gnt;
  assign decode_miss = r_miss;
  assign timeout_err = r_terr;

endmodule

// File: tb/tb_sysarb_mux.sv
// Bench for sysarb_mux: randomized scenarios against a decode/round-robin model.
module tb_sysarb_mux;
  import sysarb_pkg::*;

  localparam int unsigned NM = 2;
  localparam int unsigned NS = 4;
  localparam logic [15:0] TB_BASE [NS] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000};
  localparam logic [15:0] TB_MASK [NS] = '{16'hC000, 16'hC000, 16'hC000, 16'hF000};
  localparam int          TB_WS   [NS] = '{0, 1, 3, 0};
  localparam int unsigned TB_TIMEOUT = 8;
  localparam Z80SlaveBus  SB_IDLE  = '{dslave: 8'h00, mwait: 1'b1};
  localparam Z80SlaveBus  SB_UNMAP = '{dslave: 8'hFF, mwait: 1'b1};

  logic                  clk = 1'b0;
  logic                  reset_n;
  Z80MasterBus [NM-1:0]  m_ins;
  logic        [NM-1:0]  req, strobe;
  Z80SlaveBus  [NS-1:0]  s_ins;
  logic        [NM-1:0]  gnt;
  Z80MasterBus           master_out;
  logic        [NS-1:0]  slave_cs;
  Z80SlaveBus            slave_out;
  logic                  decode_miss, timeout_err;

  int n_pass  = 0;
  int n_total = 0;
  int tb_last = NM - 1;

  always #5 clk = ~clk;

  sysarb_mux #(
    .MASTER_QTY (NM),
    .SLAVE_QTY  (NS),
    .SLAVE_BASE ({16'hC000, 16'h8000, 16'h4000, 16'h0000}),
    .SLAVE_MASK ({16'hF000, 16'hC000, 16'hC000, 16'hC000}),
    .SLAVE_WS   ({4'd0, 4'd3, 4'd1, 4'd0}),
    .TIMEOUT    (TB_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .master_ins  (m_ins),
    .req         (req),
    .strobe      (strobe),
    .slave_ins   (s_ins),
    .gnt         (gnt),
    .master_out  (master_out),
    .slave_cs    (slave_cs),
    .slave_out   (slave_out),
    .decode_miss (decode_miss),
    .timeout_err (timeout_err)
  );

  // Reference: first region (lowest index) whose masked address equals its base.
  function automatic int model_decode(input logic [15:0] a);
    for (int s = 0; s < int'(NS); s++)
      if ((a & TB_MASK[s]) == TB_BASE[s]) return s;
    return -1;
  endfunction

  // Reference: walk masters starting after the last owner.
  function automatic int model_pick(input logic [NM-1:0] r, input int last);
    for (int i = 1; i <= int'(NM); i++) begin
      int c;
      c = (last + i) % int'(NM);
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [NM-1:0] onehot_m(input int m);
    logic [NM-1:0] v;
    v = '0;
    if (m >= 0) v[m] = 1'b1;
    return v;
  endfunction

  function automatic logic [NS-1:0] onehot_s(input int s);
    logic [NS-1:0] v;
    v = '0;
    if (s >= 0) v[s] = 1'b1;
    return v;
  endfunction

  function automatic Z80MasterBus rand_master(input logic [15:0] a);
    logic [31:0] r;
    Z80MasterBus b;
    r = $urandom;
    b = r[$bits(Z80MasterBus)-1:0];
    b.addr = a;
    return b;
  endfunction

  function automatic Z80SlaveBus rand_slave(input logic mw);
    Z80SlaveBus b;
    b.dslave = 8'($urandom);
    b.mwait  = mw;
    return b;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req = '0;
    strobe = '0;
    #2;
    reset_n = 1'b1;
    tb_last = NM - 1;
    @(negedge clk);
  endtask

  // Request with pattern r; returns at the first negedge with a grant, or after 4 cycles.
  task automatic acquire(input logic [NM-1:0] r);
    @(negedge clk);
    req = r;
    for (int i = 0; i < 4 && gnt == '0; i++) @(negedge clk);
  endtask

  task automatic start_cycle(input int m, input logic [15:0] a);
    m_ins[m]  = rand_master(a);
    strobe    = '0;
    strobe[m] = 1'b1;
    @(negedge clk);
  endtask

  task automatic release_bus();
    @(negedge clk);
    strobe = '0;
    @(negedge clk);
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req = '0;
    strobe = '0;
    for (int i = 0; i < int'(NM); i++) m_ins[i] = rand_master(16'($urandom));
    for (int s = 0; s < int'(NS); s++) s_ins[s] = rand_slave(1'($urandom));
    #12;
    n_total++; if (gnt !== '0) $display("FAIL reset_gnt got=%b exp=0", gnt); else n_pass++;
    n_total++; if (master_out !== '0) $display("FAIL reset_master_out got=%h exp=0", master_out); else n_pass++;
    n_total++; if (slave_cs !== '0) $display("FAIL reset_slave_cs got=%b exp=0", slave_cs); else n_pass++;
    n_total++; if (slave_out !== SB_IDLE) $display("FAIL reset_slave_out got=%h exp=%h", slave_out, SB_IDLE); else n_pass++;
    n_total++; if (decode_miss !== 1'b0) $display("FAIL reset_decode_miss got=%b exp=0", decode_miss); else n_pass++;
    n_total++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    tb_last = NM - 1;
  endtask

  task automatic test_basic();
    int exp_m;
    s_ins[0] = rand_slave(1'b1);
    acquire(2'b01);
    exp_m = model_pick(2'b01, tb_last);
    n_total++; if (gnt !== onehot_m(exp_m)) $display("FAIL basic_gnt got=%b exp=%b", gnt, onehot_m(exp_m)); else n_pass++;
    tb_last = exp_m;
    n_total++; if (master_out !== m_ins[0]) $display("FAIL basic_owned_bus got=%h exp=%h", master_out, m_ins[0]); else n_pass++;
    n_total++; if (slave_out !== SB_IDLE) $display("FAIL basic_owned_slave_out got=%h exp=%h", slave_out, SB_IDLE); else n_pass++;
    start_cycle(0, 16'h0010);
    n_total++; if (slave_cs !== onehot_s(model_decode(16'h0010))) $display("FAIL basic_cs got=%b exp=%b", slave_cs, onehot_s(model_decode(16'h0010))); else n_pass++;
    n_total++; if (decode_miss !== 1'b0) $display("FAIL basic_miss got=%b exp=0", decode_miss); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      s_ins[0] = rand_slave(1'b1);
      #1;
      n_total++; if (slave_out !== s_ins[0]) $display("FAIL basic_track got=%h exp=%h", slave_out, s_ins[0]); else n_pass++;
      @(negedge clk);
    end
    release_bus();
    n_total++; if (gnt !== '0) $display("FAIL basic_release_gnt got=%b exp=0", gnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int exp_m, gap;
    do_reset();
    req = '1;
    for (int k = 0; k < 3; k++) begin
      gap = 0;
      @(negedge clk);
      while (gnt == '0 && gap < 4) begin
        gap++;
        req = '1;
        @(negedge clk);
      end
      exp_m = model_pick('1, tb_last);
      n_total++; if (gnt !== onehot_m(exp_m)) $display("FAIL b2b_gnt k=%0d got=%b exp=%b", k, gnt, onehot_m(exp_m)); else n_pass++;
      if (k > 0) begin
        n_total++; if (gap != 1) $display("FAIL b2b_idle_gap k=%0d got=%0d exp=1", k, gap); else n_pass++;
      end
      tb_last = exp_m;
      m_ins[exp_m]  = rand_master(16'($urandom));
      strobe[exp_m] = 1'b1;
      #1;
      n_total++; if (master_out !== m_ins[exp_m]) $display("FAIL b2b_bus k=%0d got=%h exp=%h", k, master_out, m_ins[exp_m]); else n_pass++;
      @(negedge clk);
      strobe = '0;
      @(negedge clk);
      req[exp_m] = 1'b0;
    end
    release_bus();
  endtask

  task automatic test_wait_states();
    int m, exp_m, waits;
    logic [15:0] a;
    s_ins[2] = rand_slave(1'b1);
    m = $urandom_range(0, NM - 1);
    acquire(onehot_m(m));
    exp_m = model_pick(onehot_m(m), tb_last);
    n_total++; if (gnt !== onehot_m(exp_m)) $display("FAIL ws_gnt got=%b exp=%b", gnt, onehot_m(exp_m)); else n_pass++;
    tb_last = exp_m;
    a = 16'h8000 | (16'($urandom) & 16'h3FFF);
    start_cycle(m, a);
    n_total++; if (slave_cs !== onehot_s(model_decode(a))) $display("FAIL ws_cs got=%b exp=%b", slave_cs, onehot_s(model_decode(a))); else n_pass++;
    waits = 0;
    while (slave_out.mwait == 1'b0 && waits < 12) begin
      waits++;
      @(negedge clk);
    end
    n_total++; if (waits != TB_WS[model_decode(a)]) $display("FAIL ws_count got=%0d exp=%0d", waits, TB_WS[model_decode(a)]); else n_pass++;
    n_total++; if (slave_out !== s_ins[2]) $display("FAIL ws_after got=%h exp=%h", slave_out, s_ins[2]); else n_pass++;
    release_bus();
  endtask

  task automatic test_decode_miss();
    int m, exp_m;
    for (int s = 0; s < int'(NS); s++) s_ins[s] = rand_slave(1'b0);
    m = $urandom_range(0, NM - 1);
    acquire(onehot_m(m));
    exp_m = model_pick(onehot_m(m), tb_last);
    n_total++; if (gnt !== onehot_m(exp_m)) $display("FAIL miss_gnt got=%b exp=%b", gnt, onehot_m(exp_m)); else n_pass++;
    tb_last = exp_m;
    start_cycle(m, 16'hFFFF);
    n_total++; if (decode_miss !== (model_decode(16'hFFFF) < 0)) $display("FAIL miss_pulse got=%b exp=1", decode_miss); else n_pass++;
    n_total++; if (slave_cs !== '0) $display("FAIL miss_cs got=%b exp=0", slave_cs); else n_pass++;
    n_total++; if (slave_out !== SB_UNMAP) $display("FAIL miss_slave_out got=%h exp=%h", slave_out, SB_UNMAP); else n_pass++;
    @(negedge clk);
    n_total++; if (decode_miss !== 1'b0) $display("FAIL miss_single_pulse got=%b exp=0", decode_miss); else n_pass++;
    n_total++; if (slave_out !== SB_UNMAP) $display("FAIL miss_slave_out_hold got=%h exp=%h", slave_out, SB_UNMAP); else n_pass++;
    release_bus();
  endtask

  task automatic test_timeout();
    int m, exp_m, sl, cnt, cyc;
    logic [15:0] a;
    for (int t = 0; t < 2; t++) begin
      sl = (t == 0) ? 0 : 2;
      s_ins[sl] = rand_slave(1'b0);
      m = $urandom_range(0, NM - 1);
      acquire(onehot_m(m));
      exp_m = model_pick(onehot_m(m), tb_last);
      n_total++; if (gnt !== onehot_m(exp_m)) $display("FAIL to_gnt t=%0d got=%b exp=%b", t, gnt, onehot_m(exp_m)); else n_pass++;
      tb_last = exp_m;
      a = TB_BASE[sl] | (16'($urandom) & 16'h3FFF);
      start_cycle(m, a);
      cnt = 0;
      cyc = 0;
      while (timeout_err == 1'b0 && cyc < 30) begin
        if (slave_out.mwait == 1'b0) cnt++;
        cyc++;
        @(negedge clk);
      end
      n_total++; if (timeout_err !== 1'b1) $display("FAIL to_pulse t=%0d got=%b exp=1", t, timeout_err); else n_pass++;
      n_total++; if (cnt != int'(TB_TIMEOUT)) $display("FAIL to_wait_cycles t=%0d got=%0d exp=%0d", t, cnt, TB_TIMEOUT); else n_pass++;
      n_total++; if (slave_out !== SB_UNMAP) $display("FAIL to_slave_out t=%0d got=%h exp=%h", t, slave_out, SB_UNMAP); else n_pass++;
      n_total++; if (slave_cs !== '0) $display("FAIL to_cs t=%0d got=%b exp=0", t, slave_cs); else n_pass++;
      @(negedge clk);
      n_total++; if (timeout_err !== 1'b0) $display("FAIL to_single_pulse t=%0d got=%b exp=0", t, timeout_err); else n_pass++;
      n_total++; if (slave_out !== SB_UNMAP) $display("FAIL to_abort_hold t=%0d got=%h exp=%h", t, slave_out, SB_UNMAP); else n_pass++;
      release_bus();
    end
  endtask

  task automatic test_timeout_race();
    int m, exp_m;
    s_ins[0] = rand_slave(1'b0);
    m = $urandom_range(0, NM - 1);
    acquire(onehot_m(m));
    exp_m = model_pick(onehot_m(m), tb_last);
    n_total++; if (gnt !== onehot_m(exp_m)) $display("FAIL race_gnt got=%b exp=%b", gnt, onehot_m(exp_m)); else n_pass++;
    tb_last = exp_m;
    start_cycle(m, 16'($urandom) & 16'h3FFF);
    repeat (TB_TIMEOUT - 1) @(negedge clk);
    n_total++; if (timeout_err !== 1'b0) $display("FAIL race_early_pulse got=%b exp=0", timeout_err); else n_pass++;
    strobe = '0;
    @(negedge clk);
    n_total++; if (timeout_err !== 1'b0) $display("FAIL race_pulse got=%b exp=0", timeout_err); else n_pass++;
    n_total++; if (slave_out !== SB_IDLE) $display("FAIL race_slave_out got=%h exp=%h", slave_out, SB_IDLE); else n_pass++;
    n_total++; if (gnt !== onehot_m(exp_m)) $display("FAIL race_gnt_held got=%b exp=%b", gnt, onehot_m(exp_m)); else n_pass++;
    release_bus();
  endtask

  task automatic test_reset_mid_access();
    int exp_m;
    logic [15:0] a;
    s_ins[1] = rand_slave(1'b1);
    acquire(2'b10);
    exp_m = model_pick(2'b10, tb_last);
    tb_last = exp_m;
    a = 16'h4000 | (16'($urandom) & 16'h3FFF);
    start_cycle(exp_m, a);
    n_total++; if (slave_cs !== onehot_s(model_decode(a))) $display("FAIL rst_pre_cs got=%b exp=%b", slave_cs, onehot_s(model_decode(a))); else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_total++; if (gnt !== '0) $display("FAIL rst_gnt got=%b exp=0", gnt); else n_pass++;
    n_total++; if (slave_cs !== '0) $display("FAIL rst_cs got=%b exp=0", slave_cs); else n_pass++;
    n_total++; if (master_out !== '0) $display("FAIL rst_master_out got=%h exp=0", master_out); else n_pass++;
    n_total++; if (slave_out !== SB_IDLE) $display("FAIL rst_slave_out got=%h exp=%h", slave_out, SB_IDLE); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    tb_last = NM - 1;
    strobe = '0;
    req = '1;
    @(negedge clk);
    exp_m = model_pick('1, tb_last);
    n_total++; if (gnt !== onehot_m(exp_m)) $display("FAIL rst_priority got=%b exp=%b", gnt, onehot_m(exp_m)); else n_pass++;
    tb_last = exp_m;
    release_bus();
  endtask

  task automatic test_random_access();
    int exp_m, sel, waits;
    logic [NM-1:0] r;
    logic [15:0]   a;
    Z80SlaveBus    exp_sb;
    for (int it = 0; it < 10; it++) begin
      for (int s = 0; s < int'(NS); s++) s_ins[s] = rand_slave(1'b1);
      r = NM'($urandom_range(1, (1 << NM) - 1));
      acquire(r);
      exp_m = model_pick(r, tb_last);
      n_total++; if (gnt !== onehot_m(exp_m)) $display("FAIL rnd_gnt it=%0d got=%b exp=%b", it, gnt, onehot_m(exp_m)); else n_pass++;
      tb_last = exp_m;
      a = 16'($urandom);
      sel = model_decode(a);
      start_cycle(exp_m, a);
      n_total++; if (slave_cs !== onehot_s(sel)) $display("FAIL rnd_cs it=%0d addr=%h got=%b exp=%b", it, a, slave_cs, onehot_s(sel)); else n_pass++;
      n_total++; if (decode_miss !== (sel < 0)) $display("FAIL rnd_miss it=%0d addr=%h got=%b exp=%b", it, a, decode_miss, (sel < 0)); else n_pass++;
      m_ins[exp_m].addr = 16'($urandom);
      #1;
      n_total++; if (slave_cs !== onehot_s(sel)) $display("FAIL rnd_latched_cs it=%0d got=%b exp=%b", it, slave_cs, onehot_s(sel)); else n_pass++;
      waits = 0;
      while (slave_out.mwait == 1'b0 && waits < 12) begin
        waits++;
        @(negedge clk);
      end
      n_total++; if (waits != ((sel >= 0) ? TB_WS[sel] : 0)) $display("FAIL rnd_waits it=%0d got=%0d exp=%0d", it, waits, (sel >= 0) ? TB_WS[sel] : 0); else n_pass++;
      exp_sb = (sel >= 0) ? s_ins[sel] : SB_UNMAP;
      n_total++; if (slave_out !== exp_sb) $display("FAIL rnd_data it=%0d got=%h exp=%h", it, slave_out, exp_sb); else n_pass++;
      release_bus();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_wait_states();
    test_decode_miss();
    test_timeout();
    test_timeout_race();
    test_reset_mid_access();
    test_random_access();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
